// File: rtl/fifo_buffer_pkg.sv
// Shared definitions for the FIFO stages: default geometry, depth helper and
// the write-side FSM state encodings so every stage agrees on flag meaning.
package fifo_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    FULL = 2'd1,
    PUSH = 2'd2
  } wr_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// Push/pop handshake and status bundle between the FIFO storage stage and
// its producer/consumer.
interface fifo_buffer_if
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              push;
  logic [DATA_W-1:0] din;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              Full;
  logic              Empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, din, pop,
    input  dout, dout_valid, Full, Empty, count, overflow, underflow
  );

  modport slave (
    input  push, din, pop,
    output dout, dout_valid, Full, Empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_buffer_ptr.sv
// Wrap-bit circular pointer: ADDR_W address bits plus one MSB that toggles
// each time the address wraps, so equal addresses can be told apart.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            inc,
  output logic [ADDR_W:0] ptr
);

  logic [ADDR_W:0] ptr_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_buffer.sv
// FIFO storage and flag stage: circular memory with registered read,
// wrap-bit pointers, Full/Empty/count and single-cycle error pulses.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic         clk,
  input logic         arst,
  fifo_buffer_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              full_flag;
  logic              empty_flag;
  logic              push_ok;
  logic              pop_ok;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_reg;
  logic              dout_valid_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  // Flags depend only on the pointer registers, never on push/pop.
  assign empty_flag = (wptr == rptr);
  assign full_flag  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                      (wptr[ADDR_W] != rptr[ADDR_W]);

  // A pop frees a slot this same edge, so a push against Full still fits.
  assign pop_ok  = bus.pop & ~empty_flag;
  assign push_ok = bus.push & (~full_flag | pop_ok);

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk  (clk),
    .arst (arst),
    .inc  (push_ok),
    .ptr  (wptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk  (clk),
    .arst (arst),
    .inc  (pop_ok),
    .ptr  (rptr)
  );

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[ADDR_W-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      dout_valid_reg <= pop_ok;
      overflow_reg   <= bus.push & full_flag & ~pop_ok;
      underflow_reg  <= bus.pop & empty_flag;
      if (pop_ok) begin
        dout_reg <= mem[rptr[ADDR_W-1:0]];
      end
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.Full       = full_flag;
  assign bus.Empty      = empty_flag;
  assign bus.count      = wptr - rptr;
  assign bus.overflow   = overflow_reg;
  assign bus.underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fifo_buffer;

  localparam int DEPTH = 8;

  logic clk;
  logic arst;

  fifo_buffer_if bus ();

  fifo_buffer dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every valid output word must be the next one the model released.
  always @(negedge clk) begin
    if (!arst && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dout_unexpected: got 0x%0h expected no valid word at %0t",
                 bus.dout, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("dout", int'(bus.dout), int'(e));
        $display("pop  data=0x%02h exp=0x%02h", bus.dout, e);
      end
    end
  end

  task automatic chk_flags(input bit dv, input bit ovf, input bit unf);
    chk("count", int'(bus.count), model_q.size());
    chk("Full", int'(bus.Full), int'(model_q.size() == DEPTH));
    chk("Empty", int'(bus.Empty), int'(model_q.size() == 0));
    chk("dout_valid", int'(bus.dout_valid), int'(dv));
    chk("overflow", int'(bus.overflow), int'(ovf));
    chk("underflow", int'(bus.underflow), int'(unf));
  endtask

  // One clock of stimulus; the model decides acceptance from occupancy alone.
  task automatic do_cycle(input bit p, input logic [7:0] d, input bit q);
    bit pop_ok, push_ok, ovf, unf;
    bus.push = p;
    bus.din  = d;
    bus.pop  = q;
    pop_ok  = q && (model_q.size() != 0);
    push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
    ovf     = p && !push_ok;
    unf     = q && (model_q.size() == 0);
    if (pop_ok)  exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    $display("cyc  push=%0d din=0x%02h pop=%0d -> count=%0d ovf=%0d unf=%0d",
             p, d, q, bus.count, bus.overflow, bus.underflow);
    chk_flags(pop_ok, ovf, unf);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_Empty"}, int'(bus.Empty), 1);
    chk({tag, "_Full"}, int'(bus.Full), 0);
    chk({tag, "_dout"}, int'(bus.dout), 0);
    chk({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_underflow"}, int'(bus.underflow), 0);
  endtask

  // Asynchronous reset checked before any clock edge has occurred.
  task automatic pulse_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    arst = 1'b1;
    #1;
    model_q.delete();
    exp_q.delete();
    $display("rst  asserted");
    check_reset_state("reset");
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) do_cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 8'h00;
    arst = 1'b0;
    #3;
    pulse_reset();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    do_cycle(1'b1, 8'hC3, 1'b1);
    pulse_reset();
    do_cycle(1'b0, 8'h00, 1'b1);

    // Fill and drain
    for (int i = 1; i <= 8; i++) do_cycle(1'b1, 8'(i), 1'b0);
    // Overflow against Full
    do_cycle(1'b1, 8'hAA, 1'b0);
    drain();
    do_cycle(1'b0, 8'h00, 1'b0);

    // Empty with push and pop together
    do_cycle(1'b1, 8'h55, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b0);

    // Full with push and pop together
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0);
    do_cycle(1'b1, 8'h77, 1'b1);
    drain();

    // Streaming across the wrap at occupancy 2
    do_cycle(1'b1, 8'h20, 1'b0);
    do_cycle(1'b1, 8'h21, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    drain();

    // Random traffic: push-heavy, then pop-heavy, to visit both extremes
    for (int i = 0; i < 150; i++)
      do_cycle(1'($urandom_range(0, 99) < 70), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 99) < 35));
    for (int i = 0; i < 150; i++)
      do_cycle(1'($urandom_range(0, 99) < 35), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 99) < 70));
    drain();
    do_cycle(1'b0, 8'h00, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
